chunk_add_sequencer: RTL
========================

CHUNK_ADD_SEQUENCER -- requirements
Module: chunk_add_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, meaning the chunk width in bits, which equals the width of the external Adder.
REQ-002 SHALL have parameter W, default 4, meaning the number of chunks per operand (W >= 2); the operand width is N*W.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a request.
REQ-007 SHALL have port a, input, N*W bits: operand A.
REQ-008 SHALL have port b, input, N*W bits: operand B.
REQ-009 SHALL have port sub, input, 1 bit: 1 = compute A-B, 0 = compute A+B.
REQ-010 SHALL have port add_x, output, N bits: chunk of A driven to the Adder x input.
REQ-011 SHALL have port add_y, output, N bits: chunk of effective B driven to the Adder y input.
REQ-012 SHALL have port add_cin, output, 1 bit: carry driven to the Adder carryin input.
REQ-013 SHALL have port add_sum, input, N bits: the Adder sum output.
REQ-014 SHALL have port add_cout, input, 1 bit: the Adder carryout output.
REQ-015 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-016 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-017 SHALL have port result, output, N*W bits: the sum or difference.
REQ-018 SHALL have port cout, output, 1 bit: final carry; for subtraction, 1 = no borrow.
REQ-019 SHALL have port ovf, output, 1 bit: signed overflow flag.
REQ-020 SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-021 SHALL implement FSM states IDLE, RUN and DONE.
REQ-022 SHALL drive in_ready=1 only in IDLE; acceptance occurs on an edge where in_valid&&in_ready.
REQ-023 On acceptance, SHALL latch a, b_eff = sub ? ~b : b, and carry = sub; SHALL clear the chunk counter and go to RUN.
REQ-024 In RUN with counter k, SHALL drive add_x = A[k*N +: N], add_y = b_eff[k*N +: N], add_cin = carry; the Adder is combinational, so the result is captured in the same cycle.
REQ-025 Each RUN edge SHALL write result[k*N +: N] <= add_sum and carry <= add_cout, then increment k.
REQ-026 At the edge where k = W-1, SHALL go to DONE; out_valid SHALL rise exactly W edges after the accepting edge.
REQ-027 In DONE, SHALL hold out_valid, result, cout and ovf stable until out_valid&&out_ready, then return to IDLE; there is no same-edge re-accept.
REQ-028 SHALL set cout = carry after the final chunk.
REQ-029 Outside RUN, SHALL drive add_x, add_y and add_cin to 0.
REQ-030 Inputs a, b and sub SHALL be ignored outside the accepting edge.
REQ-031 Wrap-around SHALL be modulo 2^(N*W), with no saturation.

Reset
REQ-032 While reset=1, SHALL set state=IDLE, k=0, carry=0, result=0, cout=0, ovf=0, out_valid=0 and in_ready=1.
REQ-033 Reset asserted mid-RUN or in DONE SHALL abort the operation; no out_valid SHALL follow, and the next acceptance starts fresh.

Configuration
REQ-034 With macro CHUNK_ADD_SIGNED_OVF_EN defined, SHALL compute ovf at the DONE transition as (A[MSB]==b_eff[MSB]) && (result[MSB]!=A[MSB]).
REQ-035 Without CHUNK_ADD_SIGNED_OVF_EN, SHALL tie ovf to 0 and include no overflow logic.

Verification (N=8, W=4, behavioural Adder attached)
REQ-036 SHALL cover add with carry across all chunks: a=0xFFFFFFFF, b=0x00000001, sub=0 -> result=0x00000000, cout=1, out_valid 4 edges after acceptance.
REQ-037 SHALL cover subtract with borrow: a=5, b=7, sub=1 -> result=0xFFFFFFFE, cout=0, ovf=0.
REQ-038 SHALL cover signed overflow with the macro defined: a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, ovf=1; without the macro -> ovf=0.
REQ-039 SHALL cover backpressure: out_ready held low for 3 cycles after out_valid -> result and flags stable, in_ready=0, no new acceptance; handshake -> in_ready=1 next cycle.
REQ-040 SHALL cover reset mid-operation: reset pulsed during RUN at k=2 -> all outputs at reset values, out_valid never rises, next request a=1, b=2 -> result=3.
REQ-041 SHALL cover Adder port driving: during RUN of a=0x44332211, b=0x88776655, add_x SHALL sequence 0x11, 0x22, 0x33, 0x44, and add_y SHALL sequence 0x55, 0x66, 0x77, 0x88.

Source files
------------

// File: rtl/chunk_add_sequencer.sv
// chunk_add_sequencer
//   Performs an N*W-bit add or subtract by sequencing W chunks through an
//   external N-bit combinational Adder, one chunk per clock. The lowest chunk
//   goes first, and the carry is rippled between chunks in a register.
//
//   Optional feature: define CHUNK_ADD_SIGNED_OVF_EN to compute the signed
//   overflow flag. Without the macro, ovf is tied to 0.
//
//   Ports
//     clk, reset          : rising-edge clock, asynchronous active-high reset
//     in_valid / in_ready : request handshake (in_ready is high only in IDLE)
//     a, b, sub           : operands; sub=1 computes a-b, sub=0 computes a+b
//     add_x/add_y/add_cin : drive the external Adder (all zero outside RUN)
//     add_sum/add_cout    : results from the external Adder
//     out_valid/out_ready : result handshake (result is held while waiting)
//     result, cout, ovf   : sum or difference, final carry, signed overflow
module chunk_add_sequencer #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  input  logic           sub,
  output logic [N-1:0]   add_x,
  output logic [N-1:0]   add_y,
  output logic           add_cin,
  input  logic [N-1:0]   add_sum,
  input  logic           add_cout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] result,
  output logic           cout,
  output logic           ovf
);

  localparam int KW  = (W > 1) ? $clog2(W) : 1;
  localparam int MSB = N*W - 1;
  localparam logic [KW-1:0] KLAST = KW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   k;
  logic            carry;
  logic [N*W-1:0]  a_q;
  logic [N*W-1:0]  b_q;
  logic            accept;
  logic            last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == RUN) && (k == KLAST);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        add_x   = a_q[k*N +: N];
        add_y   = b_q[k*N +: N];
        add_cin = carry;
        if (k == KLAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      k      <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q   <= a;
        b_q   <= sub ? ~b : b;
        carry <= sub;
        k     <= '0;
      end else if (state == RUN) begin
        result[k*N +: N] <= add_sum;
        carry            <= add_cout;
        k                <= k + KW'(1);
        if (last) cout <= add_cout;
      end
    end
  end

`ifdef CHUNK_ADD_SIGNED_OVF_EN
  // The result MSB is not registered yet on the final edge, so it is taken
  // straight from the Adder's top sum bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf <= 1'b0;
    else if (last)
      ovf <= (a_q[MSB] == b_q[MSB]) && (add_sum[N-1] != a_q[MSB]);
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
